// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, ALU decode classes,
// opcode/funct encodings and the ALU operation codes also used by the ALU itself.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB, S_BRANCH, S_JUMP
   } state_t;

   // Which part of the instruction the ALU code is derived from in a given state
   typedef enum logic [2:0] {
      CLS_NONE, CLS_ADD, CLS_R, CLS_I, CLS_BR, CLS_JMP
   } alu_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_IMUL  = 6'h1C;
   localparam logic [5:0] OP_DIVI  = 6'h1A;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLE   = 6'h06;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_BLT   = 6'h14;
   localparam logic [5:0] OP_BGE   = 6'h15;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOT = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_NOT  = 5'd2;
   localparam logic [4:0] ALU_SLL  = 5'd3;
   localparam logic [4:0] ALU_SRL  = 5'd4;
   localparam logic [4:0] ALU_AND  = 5'd5;
   localparam logic [4:0] ALU_OR   = 5'd6;
   localparam logic [4:0] ALU_SLT  = 5'd7;
   localparam logic [4:0] ALU_BEQ  = 5'd8;
   localparam logic [4:0] ALU_BNE  = 5'd9;
   localparam logic [4:0] ALU_BGT  = 5'd10;
   localparam logic [4:0] ALU_BGE  = 5'd11;
   localparam logic [4:0] ALU_BLT  = 5'd12;
   localparam logic [4:0] ALU_BLE  = 5'd13;
   localparam logic [4:0] ALU_JUMP = 5'd14;
   localparam logic [4:0] ALU_IMUL = 5'd15;
   localparam logic [4:0] ALU_DIVI = 5'd16;
   localparam logic [4:0] ALU_SRA  = 5'd17;

   function automatic logic is_muldiv(input logic [5:0] op);
      return (op == OP_IMUL) || (op == OP_DIVI);
   endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU operation decode: maps the controller's ALU class plus op/funct
// to the 5-bit ALU code, flagging encodings that have no defined operation.
module mips_alu_decode
   import mips_ctrl_pkg::*;
(
   input  alu_cls_t    i_cls,
   input  logic [5:0]  i_op,
   input  logic [5:0]  i_funct,
   output logic [4:0]  o_alu_cnt,
   output logic        o_valid
);

   always_comb begin
      o_alu_cnt = ALU_ADD;
      o_valid   = 1'b0;
      case (i_cls)
         CLS_ADD: o_valid = 1'b1;
         CLS_JMP: begin
            o_alu_cnt = ALU_JUMP;
            o_valid   = 1'b1;
         end
         CLS_R: begin
            o_valid = 1'b1;
            case (i_funct)
               FN_ADD:  o_alu_cnt = ALU_ADD;
               FN_SUB:  o_alu_cnt = ALU_SUB;
               FN_AND:  o_alu_cnt = ALU_AND;
               FN_OR:   o_alu_cnt = ALU_OR;
               FN_NOT:  o_alu_cnt = ALU_NOT;
               FN_SLT:  o_alu_cnt = ALU_SLT;
               FN_SLL:  o_alu_cnt = ALU_SLL;
               FN_SRL:  o_alu_cnt = ALU_SRL;
               FN_SRA:  o_alu_cnt = ALU_SRA;
               default: o_valid   = 1'b0;
            endcase
         end
         CLS_I: begin
            o_valid = 1'b1;
            case (i_op)
               OP_ADDI: o_alu_cnt = ALU_ADD;
               OP_IMUL: o_alu_cnt = ALU_IMUL;
               OP_DIVI: o_alu_cnt = ALU_DIVI;
               default: o_valid   = 1'b0;
            endcase
         end
         CLS_BR: begin
            o_valid = 1'b1;
            case (i_op)
               OP_BEQ:  o_alu_cnt = ALU_BEQ;
               OP_BNE:  o_alu_cnt = ALU_BNE;
               OP_BLE:  o_alu_cnt = ALU_BLE;
               OP_BGT:  o_alu_cnt = ALU_BGT;
               OP_BLT:  o_alu_cnt = ALU_BLT;
               OP_BGE:  o_alu_cnt = ALU_BGE;
               default: o_valid   = 1'b0;
            endcase
         end
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: Moore-decoded control lines per state,
// with a down counter stretching EXEC_I for multi-cycle multiply/divide.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        pc_en,
   output logic        iord,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_source,
   output logic [4:0]  alu_cnt,
   output logic        illegal
);

   localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_next;
   alu_cls_t   w_cls;
   logic       w_alu_vld;
   logic       w_pc_write;
   logic       w_branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RESET;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   mips_alu_decode u_alu_decode (
      .i_cls     (w_cls),
      .i_op      (op),
      .i_funct   (funct),
      .o_alu_cnt (alu_cnt),
      .o_valid   (w_alu_vld)
   );

   // Branch resolution uses the live zero flag of the comparison the ALU is doing now
   assign pc_en = w_pc_write | (w_branch & zero);

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_cls      = CLS_NONE;
      w_pc_write = 1'b0;
      w_branch   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_source  = 2'd0;
      illegal    = 1'b0;
      case (r_state)
         S_RESET: w_next = S_FETCH;
         S_FETCH: begin
            ir_write   = 1'b1;
            w_pc_write = 1'b1;
            alu_src_b  = 2'd1;
            w_cls      = CLS_ADD;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            w_cls     = CLS_ADD;
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXEC_R;
               OP_ADDI, OP_IMUL, OP_DIVI: begin
                  w_next     = S_EXEC_I;
                  w_cnt_next = is_muldiv(op) ? MD_LOAD : 4'd0;
               end
               OP_BEQ, OP_BNE, OP_BLE, OP_BGT, OP_BLT, OP_BGE: w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  w_next  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            w_cls     = CLS_ADD;
            w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord   = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            w_next    = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            w_cls     = CLS_R;
            if (w_alu_vld) begin
               w_next = S_RTYPE_WB;
            end else begin
               illegal = 1'b1;
               w_next  = S_FETCH;
            end
         end
         S_RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            w_cls     = CLS_R;
            w_next    = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            w_cls     = CLS_I;
            if (r_cnt == 4'd0) begin
               w_next = S_ITYPE_WB;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_ITYPE_WB: begin
            reg_write = 1'b1;
            w_cls     = CLS_I;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            pc_source = 2'd1;
            w_branch  = 1'b1;
            w_cls     = CLS_BR;
            w_next    = S_FETCH;
         end
         S_JUMP: begin
            pc_source  = 2'd2;
            w_pc_write = 1'b1;
            w_cls      = CLS_JMP;
            w_next     = S_FETCH;
         end
         default: w_next = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, checked every cycle.
module tb_mips_multicycle_ctrl;

   localparam int MD = 4;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_source;
   logic [4:0] alu_cnt;
   logic [17:0] dv;

   int n_cmp = 0;
   int n_fail = 0;
   logic [17:0] seq[$];
   logic [17:0] expq[$];

   mips_multicycle_ctrl #(.MULDIV_CYCLES(MD)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_cnt(alu_cnt), .illegal(illegal)
   );

   assign dv = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_source, alu_cnt, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Argument order matches the packing of dv
   function automatic logic [17:0] mk(input int pcen, input int io, input int mw, input int irw,
                                      input int rdst, input int m2r, input int rw, input int asa,
                                      input int asb, input int pcs, input int alu, input int ill);
      return {pcen[0], io[0], mw[0], irw[0], rdst[0], m2r[0], rw[0], asa[0],
              asb[1:0], pcs[1:0], alu[4:0], ill[0]};
   endfunction

   function automatic int rcode(input logic [5:0] f);
      case (f)
         6'h20: return 0;   6'h22: return 1;   6'h24: return 5;
         6'h25: return 6;   6'h27: return 2;   6'h2A: return 7;
         6'h00: return 3;   6'h02: return 4;   6'h03: return 17;
         default: return -1;
      endcase
   endfunction

   function automatic int bcode(input logic [5:0] o);
      case (o)
         6'h04: return 8;   6'h05: return 9;   6'h06: return 13;
         6'h07: return 10;  6'h14: return 12;  6'h15: return 11;
         default: return -1;
      endcase
   endfunction

   function automatic int icode(input logic [5:0] o);
      case (o)
         6'h08: return 0;   6'h1C: return 15;  6'h1A: return 16;
         default: return -1;
      endcase
   endfunction

   // Expected control vectors, one per cycle, from FETCH up to the instruction's last cycle
   task automatic model(input logic [5:0] o, input logic [5:0] f, input bit z);
      bit is_mem, is_r, is_i, is_br, is_j;
      int code;
      seq.delete();
      is_mem = (o == 6'h23) || (o == 6'h2B);
      is_r   = (o == 6'h00);
      is_i   = (icode(o) >= 0);
      is_br  = (bcode(o) >= 0);
      is_j   = (o == 6'h02);
      seq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0,
                       (is_mem || is_r || is_i || is_br || is_j) ? 0 : 1));
      if (is_mem) begin
         seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
         if (o == 6'h23) begin
            seq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            seq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
         end else begin
            seq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         end
      end else if (is_r) begin
         code = rcode(f);
         if (code < 0) begin
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
         end else begin
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, code, 0));
            seq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, code, 0));
         end
      end else if (is_i) begin
         code = icode(o);
         for (int k = 0; k < ((code == 0) ? 1 : MD); k++)
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, code, 0));
         seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, code, 0));
      end else if (is_br) begin
         seq.push_back(mk(z ? 1 : 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, bcode(o), 0));
      end else if (is_j) begin
         seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 14, 0));
      end
   endtask

   // Every cycle the model has an expectation for, compare all outputs mid-cycle
   always @(negedge clk) begin
      if (expq.size() > 0) check("cycle_outputs", dv, expq.pop_front());
   end

   // Called at posedge+1 with the DUT in FETCH; leaves it in the next FETCH
   task automatic run(input string name, input logic [5:0] o, input logic [5:0] f, input bit z,
                      input int exp_len, input int chk_idx, input logic [17:0] chk_val);
      model(o, f, z);
      check({name, "_len"}, seq.size(), exp_len);
      op = o; funct = f; zero = z;
      foreach (seq[k]) expq.push_back(seq[k]);
      for (int i = 0; i < exp_len; i++) begin
         if (i == chk_idx) check(name, dv, chk_val);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("reset_outputs", dv, 18'd0);
      @(negedge clk);
      reset = 1'b0; zero = 1'b0;
      #1 check("reset_state_after_release", dv, 18'd0);
      @(posedge clk);
      #1;

      run("first_fetch",     6'h00, 6'h20, 0, 4, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
      run("slt_exec",        6'h00, 6'h2A, 0, 4, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0));
      run("add_rtype_wb",    6'h00, 6'h20, 1, 4, 3, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      run("lw_memrd",        6'h23, 6'h00, 0, 5, 3, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run("lw_memwb",        6'h23, 6'h00, 0, 5, 4, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      run("sw_memwr",        6'h2B, 6'h00, 0, 4, 3, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run("bgt_taken",       6'h07, 6'h00, 1, 3, 2, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 10, 0));
      run("bgt_not_taken",   6'h07, 6'h00, 0, 3, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 10, 0));
      run("imul_wb_cycle7",  6'h1C, 6'h00, 0, 7, 6, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 15, 0));
      run("divi_exec_last",  6'h1A, 6'h00, 0, 7, 5, mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 16, 0));
      run("addi_exec",       6'h08, 6'h00, 0, 4, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
      run("jump",            6'h02, 6'h00, 0, 3, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 14, 0));
      run("illegal_op",      6'h3F, 6'h00, 0, 2, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
      run("illegal_funct",   6'h00, 6'h3F, 0, 3, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
      run("beq_taken",       6'h04, 6'h00, 1, 3, 2, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 0));
      run("bne",             6'h05, 6'h00, 0, 3, -1, 18'd0);
      run("ble",             6'h06, 6'h00, 1, 3, 2, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 13, 0));
      run("blt",             6'h14, 6'h00, 0, 3, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12, 0));
      run("bge",             6'h15, 6'h00, 1, 3, 2, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11, 0));
      run("sub",             6'h00, 6'h22, 0, 4, -1, 18'd0);
      run("and",             6'h00, 6'h24, 0, 4, -1, 18'd0);
      run("or",              6'h00, 6'h25, 0, 4, -1, 18'd0);
      run("not",             6'h00, 6'h27, 0, 4, -1, 18'd0);
      run("sll",             6'h00, 6'h00, 0, 4, -1, 18'd0);
      run("srl",             6'h00, 6'h02, 0, 4, -1, 18'd0);
      run("sra_exec",        6'h00, 6'h03, 0, 4, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 17, 0));

      // sw interrupted by reset while in MEMWR
      model(6'h2B, 6'h00, 1'b0);
      op = 6'h2B; funct = 6'h00; zero = 1'b0;
      for (int k = 0; k < 3; k++) expq.push_back(seq[k]);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("abort_memwr_active", {31'd0, mem_write}, 32'd1);
      reset = 1'b1;
      #1 check("abort_async_outputs", dv, 18'd0);
      @(negedge clk);
      check("abort_held_outputs", dv, 18'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run("post_abort_lw",   6'h23, 6'h00, 0, 5, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
